// File: rtl/frame_scanout.sv
// rtl/frame_scanout.sv - frame buffer read-side master streaming pixels with line/frame markers
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   frame_rdy         level: a complete frame sits in the buffer
//   fb_rd_en          active-low read strobe, fb_rd_addr alongside it
//   fb_rd_data        read data, valid the cycle after the strobe is sampled
//   pix_*             pixel stream (valid/ready) with sof/eol/eof markers
//   busy, frame_done  activity level and one-cycle end-of-frame pulse
module frame_scanout #(
    parameter int DATA_WIDTH      = 24,
    parameter int PIX_PER_LINE    = 4,
    parameter int LINES_PER_FRAME = 2,
    parameter int ADDR_WIDTH      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_rdy,
    output logic                  fb_rd_en,
    output logic [ADDR_WIDTH-1:0] fb_rd_addr,
    input  logic [DATA_WIDTH-1:0] fb_rd_data,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_sof,
    output logic                  pix_eol,
    output logic                  pix_eof,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int N  = PIX_PER_LINE * LINES_PER_FRAME;
    localparam int PW = (PIX_PER_LINE > 1) ? $clog2(PIX_PER_LINE) : 1;
    localparam int LW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);
    localparam logic [PW-1:0]         LAST_PIX  = PW'(PIX_PER_LINE - 1);
    localparam logic [LW-1:0]         LAST_LINE = LW'(LINES_PER_FRAME - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic                    rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    pend_q;
    logic                    done_q, done_d;

    logic [DATA_WIDTH-1:0]   mem_q [4];
    logic [1:0]              wr_ptr_q, rd_ptr_q, rd_ptr_nx;
    logic [2:0]              occ_q, occ_d;

    logic [DATA_WIDTH-1:0]   pix_data_q, pix_data_d;
    logic                    valid_q, sof_q, eol_q, eof_q;
    logic                    sof_d, eol_d, eof_d;
    logic [PW-1:0]           pix_cnt_q, pix_cnt_d;
    logic [LW-1:0]           line_cnt_q, line_cnt_d;

    logic                    push, pop, room;

    // Buffer bookkeeping and registered output head
    always_comb begin
        // pend_q marks a strobe sampled by the buffer last edge: its data is on fb_rd_data now
        push      = pend_q;
        pop       = valid_q & pix_ready;
        occ_d     = occ_q + {2'b00, push} - {2'b00, pop};
        rd_ptr_nx = rd_ptr_q + {1'b0, pop};

        pix_data_d = pix_data_q;
        if (occ_d != 3'd0) begin
            // When the buffer drains to empty in the same cycle as a push, the new word
            // becomes the head directly rather than via the storage array.
            if (push && (occ_q == {2'b00, pop}))
                pix_data_d = fb_rd_data;
            else
                pix_data_d = mem_q[rd_ptr_nx];
        end

        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        if (pop) begin
            if (pix_cnt_q == LAST_PIX) begin
                pix_cnt_d  = '0;
                line_cnt_d = (line_cnt_q == LAST_LINE) ? '0 : line_cnt_q + LW'(1);
            end else begin
                pix_cnt_d = pix_cnt_q + PW'(1);
            end
        end

        sof_d = (occ_d != 3'd0) && (pix_cnt_d == '0) && (line_cnt_d == '0);
        eol_d = (occ_d != 3'd0) && (pix_cnt_d == LAST_PIX);
        eof_d = eol_d && (line_cnt_d == LAST_LINE);
    end

    // Issue control: the next cycle may carry a strobe only if everything already
    // buffered or in flight plus that strobe still fits in the four entries.
    always_comb begin
        state_d = state_q;
        rd_en_d = 1'b1;
        addr_d  = addr_q;
        done_d  = 1'b0;
        room    = (occ_d + {2'b00, ~rd_en_q}) <= 3'd3;

        case (state_q)
            S_IDLE: begin
                if (frame_rdy) begin
                    rd_en_d = 1'b0;
                    addr_d  = '0;
                    state_d = (LAST_ADDR == '0) ? S_DRAIN : S_READ;
                end
            end
            S_READ: begin
                if (room) begin
                    rd_en_d = 1'b0;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    if (addr_d == LAST_ADDR)
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && eof_q && (occ_d == 3'd0) && rd_en_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            rd_en_q    <= 1'b1;
            addr_q     <= '0;
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            pix_data_q <= '0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            eof_q      <= 1'b0;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            pend_q     <= ~rd_en_q;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_q + {1'b0, push};
            rd_ptr_q   <= rd_ptr_nx;
            occ_q      <= occ_d;
            pix_data_q <= pix_data_d;
            valid_q    <= (occ_d != 3'd0);
            sof_q      <= sof_d;
            eol_q      <= eol_d;
            eof_q      <= eof_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define what is live
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= fb_rd_data;
    end

    assign fb_rd_en   = rd_en_q;
    assign fb_rd_addr = addr_q;
    assign pix_data   = pix_data_q;
    assign pix_valid  = valid_q;
    assign pix_sof    = sof_q;
    assign pix_eol    = eol_q;
    assign pix_eof    = eof_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = done_q;

endmodule

// File: doc/frame_scanout.md
Name: frame_scanout

Overview:
- Read-side master for the frame buffer.
- Once a complete frame is flagged ready, it walks the buffer addresses in order and issues read strobes.
- It captures the one-cycle-latency read data into a 4-entry output buffer and streams pixels downstream on a valid/ready interface, with start/end-of-line and start/end-of-frame markers.
- It sits between frame_buf's read port and the display/output pipeline.

Parameters:
- DATA_WIDTH, 24, pixel width in bits.
- PIX_PER_LINE, 4, pixels per line; must be ≥1.
- LINES_PER_FRAME, 2, lines per frame; must be ≥1.
- ADDR_WIDTH, 3, buffer address width; 2^ADDR_WIDTH ≥ PIX_PER_LINE*LINES_PER_FRAME.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- frame_rdy  in  1  level; a full frame is present in the buffer.
- fb_rd_en  out  1  active-low read strobe to frame buffer.
- fb_rd_addr  out  ADDR_WIDTH  read address presented with fb_rd_en.
- fb_rd_data  in  DATA_WIDTH  read data, valid the cycle after the strobe is sampled.
- pix_data  out  DATA_WIDTH  output pixel.
- pix_valid  out  1  pix_data and markers are valid.
- pix_ready  in  1  downstream accepts; transfer = pix_valid & pix_ready.
- pix_sof  out  1  current pixel is the first of the frame.
- pix_eol  out  1  current pixel is the last of its line.
- pix_eof  out  1  current pixel is the last of the frame.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when the last pixel has been transferred.

Behaviour:
- Reset (async, reset=0) values:
  - state=IDLE, fb_rd_en=1 (deasserted), fb_rd_addr=0.
  - Buffer empty, pix_valid=0, pix_data=0, all markers=0.
  - busy=0, frame_done=0; all counters 0.
- Outputs are registered; no combinational path from pix_ready to pix_valid or fb_rd_en.
- Reset mid-frame abandons the frame; nothing resumes after reset release.
- States: IDLE, READ, DRAIN.
- IDLE:
  - frame_rdy=1 sampled at edge E0 → READ at E0.
  - The first strobe fb_rd_en=0 with fb_rd_addr=0 is driven from E0.
  - frame_rdy is ignored outside IDLE.
- READ:
  - A strobe is issued in a cycle only if occupancy + in_flight ≤ 3. occupancy counts buffer entries (0..4); in_flight is 1 if a strobe was issued in the previous cycle.
  - With pix_ready held high this sustains one strobe per cycle.
  - fb_rd_addr increments by 1 per issued strobe; it is held when no strobe is issued.
  - After the strobe for address N-1 (N = PIX_PER_LINE*LINES_PER_FRAME) → DRAIN. fb_rd_en is deasserted from that point.
- Capture:
  - fb_rd_data is written into the buffer at the edge after the cycle in which the strobe was sampled.
  - First pix_valid=1 therefore occurs 2 edges after E0 (from E2).
- DRAIN:
  - No strobes are issued.
  - When the buffer is empty, in_flight=0 and the last pixel has transferred: frame_done=1 for exactly one cycle → IDLE.
  - If frame_rdy is still 1 at that IDLE sample, a new frame starts (minimum one IDLE cycle between frames).
- Output buffer:
  - 4-entry FIFO; push and pop in the same cycle is allowed, and occupancy is unchanged.
  - Overflow is impossible by the issue rule.
  - pix_data and the markers remain stable while pix_valid=1 and pix_ready=0.
- Markers are computed from the output-side counters pix_cnt (0..PIX_PER_LINE-1) and line_cnt (0..LINES_PER_FRAME-1). Both advance only on a transfer.
  - pix_sof = (pix_cnt==0 && line_cnt==0).
  - pix_eol = (pix_cnt==PIX_PER_LINE-1).
  - pix_eof = pix_eol && (line_cnt==LINES_PER_FRAME-1).
  - Counters wrap to 0 after the eof transfer.
- Degenerate case PIX_PER_LINE=1: every pixel has pix_eol=1.
- Degenerate case N=1: the single pixel has sof, eol and eof all high.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release, frame_rdy=0 for 10 cycles → fb_rd_en=1, pix_valid=0, busy=0 throughout.
- Full-rate frame: buffer holds data=addr*16 for addr 0..7; frame_rdy=1 at E0, pix_ready=1 →
  - strobes at addr 0..7 on 8 consecutive cycles from E0;
  - pix_valid from E2 for 8 consecutive cycles, data 0x00,0x10..0x70;
  - sof on the 1st pixel, eol on the 4th and 8th, eof on the 8th;
  - frame_done pulse the cycle after the last transfer; busy drops.
- Backpressure: pix_ready=0 from E0 →
  - exactly 4 strobes (addr 0..3) are issued, then fb_rd_en=1;
  - pix_data holds 0x00 stable;
  - after raising pix_ready, all 8 pixels arrive in order with no loss or duplication.
- Random pix_ready (50% duty, 3 frames back-to-back, frame_rdy held 1) →
  - 24 transfers in order;
  - exactly 3 frame_done pulses;
  - exactly one IDLE cycle between frames;
  - the occupancy + in_flight ≤ 4 assertion never fails.
- Mid-frame reset: reset=0 after the 3rd transfer →
  - immediately pix_valid=0, fb_rd_en=1, busy=0;
  - after release with frame_rdy=1, the next frame restarts at addr 0 with sof on the first pixel.
- Degenerate config PIX_PER_LINE=1, LINES_PER_FRAME=1 → a single pixel with sof=eol=eof=1, followed by one frame_done pulse.
